mem_bus_ctrl: RTL

// - Load/store bus master between MEM stage and external data bus; generates the `busy` stall consumed by hazard detection.
// - Captures one core access, runs request/response handshake on the bus, returns read data/error.
// - Holds `busy` high until the access completes.
// - Sits between the MEM-stage LSU and the system data bus.

---
 rtl/mem_bus_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
// Load/store bus master sitting between the MEM-stage LSU and the system
// data bus. Captures one core access, runs the request/response handshake
// on the bus, returns load data / error, and raises `busy` to stall the
// pipeline until the access completes.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   core_req/we/addr/wdata/wstrb  access from MEM stage (level, held while stalled)
//   busy                       stall request to hazard detection
//   core_rdata                 last completed load data
//   core_err                   high in the completion cycle on bus error/timeout
//   bus_req_valid/ready        request handshake
//   bus_we/addr/wdata/wstrb    registered request fields
//   bus_rsp_valid/ready        response handshake (ready only while waiting)
//   bus_rsp_rdata/err          response payload
module mem_bus_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [DATA_W/8-1:0]   core_wstrb,
  output logic                  busy,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_err,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_rsp_valid,
  output logic                  bus_rsp_ready,
  input  logic [DATA_W-1:0]     bus_rsp_rdata,
  input  logic                  bus_rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic             err_q, err_d;
  logic             cap_req;
  logic             cap_rdata;
  logic             timeout_hit;

  // Counter saturates at TIMEOUT instead of wrapping.
  assign cnt_sat     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // The cycle in which the counter would reach TIMEOUT is the last one
  // allowed in REQ/WAIT, giving exactly TIMEOUT cycles per phase.
  assign timeout_hit = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    cap_req       = 1'b0;
    cap_rdata     = 1'b0;
    busy          = 1'b0;
    core_err      = 1'b0;
    bus_req_valid = 1'b0;
    bus_rsp_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stall combinationally so the instruction holds in MEM from the
        // first cycle; gated by rstn so the stall is released during reset.
        busy = core_req & rstn;
        if (core_req) begin
          cap_req = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        busy          = 1'b1;
        bus_req_valid = 1'b1;
        // An accepted request takes priority over a coincident timeout:
        // once the bus has taken it, the response must be collected.
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (timeout_hit) begin
          cnt_d   = cnt_sat;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      S_WAIT: begin
        busy          = 1'b1;
        bus_rsp_ready = 1'b1;
        if (bus_rsp_valid) begin
          err_d     = bus_rsp_err;
          cap_rdata = ~bus_we;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          cnt_d   = cnt_sat;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      S_DONE: begin
        // Pipeline advances this cycle; core_req still shows the same
        // instruction and must not start a second access.
        core_err = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured once in IDLE and held stable until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else if (cap_req) begin
      bus_we    <= core_we;
      bus_addr  <= core_addr;
      bus_wdata <= core_wdata;
      bus_wstrb <= core_wstrb;
    end
  end

  // Load data is taken even when the response flags an error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_rdata <= '0;
    end else if (cap_rdata) begin
      core_rdata <= bus_rsp_rdata;
    end
  end

endmodule
